sd_spi_host: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 27 ++
 rtl/sd_crc_serial.sv | 29 ++
 rtl/sd_spi_host.sv | 202 ++++++++++++++++++++
 tb/tb_sd_spi_host.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD host: FSM states,
// command codes, token values and CRC generator polynomials.
package sd_spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_GAP,
        ST_TX,
        ST_DRESP,
        ST_BUSY,
        ST_RD_TOK,
        ST_RD_DATA,
        ST_FIN
    } state_t;

    localparam logic [5:0]  CMD_READ   = 6'd17;
    localparam logic [5:0]  CMD_WRITE  = 6'd24;
    localparam logic [7:0]  TOKEN      = 8'hFE;
    localparam logic [7:0]  DRESP_OK   = 8'h05;

    // Generator polynomials without the implicit top term.
    localparam logic [6:0]  CRC7_POLY  = 7'h09;    // x^7 + x^3 + 1
    localparam logic [15:0] CRC16_POLY = 16'h1021; // x^16 + x^12 + x^5 + 1

endpackage

// File: rtl/sd_crc_serial.sv
// Bit-serial MSB-first CRC with zero initial value; clr restarts the
// remainder, en folds din into it on the rising edge.
module sd_crc_serial #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] POLY  = 'h09
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[WIDTH-1];

    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{fb}});
        end
    end

endmodule

// File: rtl/sd_spi_host.sv
// SPI-mode SD initiator: turns a single-block read/write request into a
// CMD17/CMD24 bit-serial exchange and reports data or an error flag.
module sd_spi_host
    import sd_spi_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        op,
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] rdata,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [9:0] TOUT_LAST = 10'(TIMEOUT - 1);
    localparam logic [6:0] GAP_LAST  = 7'(GAP - 1);

    state_t      state, state_nx;
    logic        op_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [6:0]  cnt;
    logic [9:0]  tcnt;
    logic [6:0]  rx_byte;
    logic [63:0] data_sr;
    logic [14:0] crc_sr;
    logic [6:0]  crc7;
    logic [15:0] crc16;

    logic [39:0] frame;
    logic [7:0]  rx_next;
    logic        accept, cnt_en, rx_shift, waiting, set_err, rd_ok;
    logic        crc7_en, crc16_en, crc16_din;

    assign accept  = (state == ST_IDLE) && in_valid;
    assign frame   = {2'b01, (op_q ? CMD_WRITE : CMD_READ), addr_q};
    assign rx_next = {rx_byte, MISO};
    assign busy    = (state != ST_IDLE) && (state != ST_FIN);
    assign done    = (state == ST_FIN);

    sd_crc_serial #(.WIDTH(7), .POLY(CRC7_POLY)) u_crc7 (
        .clk(clk), .rst_n(rst_n), .clr(state == ST_IDLE),
        .en(crc7_en), .din(MOSI), .crc(crc7)
    );

    sd_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk(clk), .rst_n(rst_n), .clr(state == ST_IDLE),
        .en(crc16_en), .din(crc16_din), .crc(crc16)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        MOSI      = 1'b1;
        cnt_en    = 1'b0;
        rx_shift  = 1'b0;
        waiting   = 1'b0;
        set_err   = 1'b0;
        rd_ok     = 1'b0;
        crc7_en   = 1'b0;
        crc16_en  = 1'b0;
        crc16_din = MISO;
        case (state)
            ST_IDLE: if (in_valid) state_nx = ST_CMD;
            ST_CMD: begin
                cnt_en = 1'b1;
                if (cnt < 7'd40) begin
                    MOSI    = frame[6'(7'd39 - cnt)];
                    crc7_en = 1'b1;
                end else if (cnt < 7'd47) begin
                    MOSI = crc7[3'(7'd46 - cnt)];
                end
                if (cnt == 7'd47) state_nx = ST_RESP;
            end
            ST_RESP, ST_DRESP: begin
                rx_shift = (cnt != 7'd0) || !MISO;
                waiting  = !rx_shift;
                cnt_en   = rx_shift;
                if (rx_shift && cnt == 7'd7) begin
                    if (state == ST_RESP) begin
                        if (rx_next != 8'h00) begin
                            set_err  = 1'b1;
                            state_nx = ST_FIN;
                        end else begin
                            state_nx = op_q ? ST_GAP : ST_RD_TOK;
                        end
                    end else if (rx_next != DRESP_OK) begin
                        set_err  = 1'b1;
                        state_nx = ST_FIN;
                    end else begin
                        state_nx = ST_BUSY;
                    end
                end
            end
            ST_GAP: begin
                cnt_en = 1'b1;
                if (cnt == GAP_LAST) state_nx = ST_TX;
            end
            ST_TX: begin
                cnt_en = 1'b1;
                if (cnt < 7'd8) begin
                    MOSI = TOKEN[3'(7'd7 - cnt)];
                end else if (cnt < 7'd72) begin
                    MOSI      = wdata_q[6'(7'd71 - cnt)];
                    crc16_en  = 1'b1;
                    crc16_din = wdata_q[6'(7'd71 - cnt)];
                end else begin
                    MOSI = crc16[4'(7'd87 - cnt)];
                end
                if (cnt == 7'd87) state_nx = ST_DRESP;
            end
            ST_BUSY: begin
                waiting = !MISO;
                if (MISO) state_nx = ST_FIN;
            end
            // The token's only 0 bit is its last one, so that 0 ends it; the
            // preceding seven samples taken in this state must all be 1.
            ST_RD_TOK: begin
                rx_shift = 1'b1;
                waiting  = MISO;
                if (!MISO) begin
                    if (rx_next != TOKEN) begin
                        set_err  = 1'b1;
                        state_nx = ST_FIN;
                    end else begin
                        state_nx = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                cnt_en   = 1'b1;
                crc16_en = (cnt < 7'd64);
                if (cnt == 7'd79) begin
                    state_nx = ST_FIN;
                    if ({crc_sr, MISO} != crc16) set_err = 1'b1;
                    else                         rd_ok   = 1'b1;
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (waiting && tcnt == TOUT_LAST) begin
            set_err  = 1'b1;
            state_nx = ST_FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            tcnt    <= '0;
            rx_byte <= '0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state_nx != state) begin
                cnt     <= '0;
                tcnt    <= '0;
                rx_byte <= '0;
            end else begin
                if (cnt_en)   cnt     <= cnt + 7'd1;
                if (waiting)  tcnt    <= tcnt + 10'd1;
                if (rx_shift) rx_byte <= rx_next[6:0];
            end
            if (accept) begin
                err   <= 1'b0;
                rdata <= '0;
            end
            if (set_err) err   <= 1'b1;
            if (rd_ok)   rdata <= data_sr;
        end
    end

    // NOTE: pure datapath registers carry no reset; each is written before
    // it is read in every transaction, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
        if (state == ST_RD_DATA) begin
            if (cnt < 7'd64) data_sr <= {data_sr[62:0], MISO};
            else             crc_sr  <= {crc_sr[13:0], MISO};
        end
    end

endmodule

// File: tb/tb_sd_spi_host.sv
// Self-checking bench for sd_spi_host: a card model drives MISO, a
// scoreboard queue holds expected completions checked by a done monitor.
module tb_sd_spi_host;

    localparam int TIMEOUT = 1023;
    localparam int GAP     = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        op       = 1'b0;
    logic [31:0] addr     = '0;
    logic [63:0] wdata    = '0;
    logic        miso     = 1'b1;
    logic        busy, done, err, mosi;
    logic [63:0] rdata;

    sd_spi_host #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .MOSI(mosi), .MISO(miso)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  mosi_bad;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC as the remainder of msg * x^w divided by the generator (zero init).
    function automatic logic [15:0] crc_ref(input logic [63:0] msg, input int nbits,
                                            input int w, input logic [16:0] gen);
        logic [79:0] r;
        r = {16'h0, msg} << w;
        for (int i = nbits + w - 1; i >= w; i--)
            if (r[i]) r = r ^ ({63'h0, gen} << (i - w));
        return r[15:0];
    endfunction

    task automatic drive(input logic b);
        @(negedge clk);
        miso = b;
        if (mosi !== 1'b1) mosi_bad = 1'b1;
    endtask

    task automatic drive_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive(v[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || done !== 1'b0) && n < 3000);
        if (busy !== 1'b0 || done !== 1'b0) check("idle_wait", {busy, done}, 2'b00);
    endtask

    // mode: 0 normal, 1 card silent (timeout), 2 reset asserted during TX
    task automatic run_txn(input logic o, input logic [31:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input int dly, input logic [7:0] resp,
                           input int bad_bit, input logic [7:0] dresp, input int busy_n,
                           input int mode);
        logic [39:0] hdr;
        logic [15:0] c7, c16;
        logic [47:0] cmd_got, cmd_exp;
        logic [87:0] tx_got, tx_exp;
        resp_t       e;
        int          n;
        wait_idle();
        e.err   = (mode == 1) || (resp != 8'h00) || (o ? (dresp != 8'h05) : (bad_bit >= 0));
        e.rdata = (e.err || o) ? 64'h0 : rd;
        if (mode != 2) exp_q.push_back(e);
        mosi_bad = 1'b0;
        in_valid = 1'b1;
        op       = o;
        addr     = a;
        wdata    = wd;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            cmd_got[47 - i] = mosi;
            if (i == 0) check("busy_after_accept", busy, 1'b1);
        end
        hdr     = {2'b01, (o ? 6'd24 : 6'd17), a};
        c7      = crc_ref({24'h0, hdr}, 40, 7, 17'h00089);
        cmd_exp = {hdr, c7[6:0], 1'b1};
        check("cmd_frame", cmd_got, cmd_exp);
        if (!o && a == 32'h0) check("cmd_bytes_addr0", cmd_got, 48'h51_0000_0000_55);

        if (mode == 1) begin
            n = 0;
            forever begin
                @(negedge clk);
                in_valid = (n == 100);
                op       = ~o;
                if (mosi !== 1'b1) mosi_bad = 1'b1;
                if (done === 1'b1 || n > TIMEOUT + 20) break;
                n++;
            end
            in_valid = 1'b0;
            check("timeout_cycles", n, TIMEOUT);
            check("mosi_idle", mosi_bad, 1'b0);
            return;
        end

        repeat (dly) drive(1'b1);
        drive_byte(resp);
        if (resp != 8'h00) begin
            repeat (4) drive(1'b1);
            check("mosi_idle", mosi_bad, 1'b0);
            return;
        end

        if (o) begin
            repeat (GAP) drive(1'b1);
            c16    = crc_ref(wd, 64, 16, 17'h11021);
            tx_exp = {8'hFE, wd, c16};
            for (int i = 0; i < 88; i++) begin
                if (mode == 2 && i == 30) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("abort_mosi", mosi, 1'b1);
                    check("abort_busy", busy, 1'b0);
                    check("abort_done", done, 1'b0);
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
                miso = 1'b1;
                tx_got[87 - i] = mosi;
            end
            check("tx_frame", tx_got, tx_exp);
            repeat (dly) drive(1'b1);
            drive_byte(dresp);
            if (dresp != 8'h05) begin
                repeat (12) drive(1'b1);
                check("mosi_idle", mosi_bad, 1'b0);
                return;
            end
            repeat (busy_n) drive(1'b0);
        end else begin
            repeat (dly) drive(1'b1);
            drive_byte(8'hFE);
            c16 = crc_ref(rd, 64, 16, 17'h11021);
            if (bad_bit >= 0) c16[bad_bit] = ~c16[bad_bit];
            for (int i = 63; i >= 0; i--) drive(rd[i]);
            for (int i = 15; i >= 0; i--) drive(c16[i]);
        end
        drive(1'b1);
        check("mosi_idle", mosi_bad, 1'b0);
    endtask

    initial begin : monitor
        resp_t e;
        logic  prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("pending_at_done", exp_q.size(), 1);
                check("busy_at_done", busy, 1'b0);
                check("busy_before_done", prev_busy, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("err", err, e.err);
                    check("rdata", rdata, e.rdata);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin : stimulus
        logic        o;
        logic [7:0]  rsp, drsp;
        int          bb;
        repeat (3) @(negedge clk);
        check("reset_mosi", mosi, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_rdata", rdata, 64'h0);
        rst_n = 1'b1;

        run_txn(1'b0, 32'h0, 64'h0, 64'h0, 3, 8'h00, -1, 8'h05, 0, 0);
        run_txn(1'b0, 32'h0000_1234, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 8'h00, -1, 8'h05, 0, 0);
        run_txn(1'b1, 32'h5, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 2, 8'h00, -1, 8'h05, 10, 0);
        run_txn(1'b0, 32'hA5A5_0001, 64'h0, {$urandom, $urandom}, 0, 8'h00, 5, 8'h05, 0, 0);
        run_txn(1'b1, 32'h9, {$urandom, $urandom}, 64'h0, 1, 8'h00, -1, 8'h0B, 0, 0);
        run_txn(1'b0, 32'h7, 64'h0, 64'h0, 0, 8'h00, -1, 8'h05, 0, 1);
        run_txn(1'b1, 32'h3, {$urandom, $urandom}, 64'h0, 0, 8'h00, -1, 8'h05, 0, 2);
        run_txn(1'b0, 32'h0BAD_F00D, 64'h0, {$urandom, $urandom}, 2, 8'h00, -1, 8'h05, 0, 0);
        run_txn(1'b0, 32'h11, 64'h0, 64'h1, 0, 8'h04, -1, 8'h05, 0, 0);

        for (int k = 0; k < 10; k++) begin
            o    = 1'($urandom_range(0, 1));
            rsp  = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            drsp = ($urandom_range(0, 3) == 0) ? 8'h0B : 8'h05;
            bb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_txn(o, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 5)), rsp, bb, drsp,
                    int'($urandom_range(0, 20)), 0);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
